// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin sharing of one registered WIDTH-bit adder among NUM_REQ requesters.
// Each grant runs IDLE->ADD->RESP, returns sum/carry with a one-cycle done pulse and counts completions.
`default_nettype none

module sum_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         btn_reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WIDTH-1:0]     op_a,
  input  logic [NUM_REQ*WIDTH-1:0]     op_b,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [WIDTH-1:0]             result,
  output logic                         overflow,
  output logic [$clog2(NUM_REQ)-1:0]   last_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             txn_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      win_q, win_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ID_W-1:0]      pick;
  logic                 pick_vld;
  int                   scan_idx;
  logic [WIDTH-1:0]     a_sel, b_sel;
  logic [WIDTH:0]       sum;
  logic [ID_W-1:0]      ptr_next;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_vld && req[scan_idx]) begin
        pick     = ID_W'(scan_idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel    = op_a[int'(win_q)*WIDTH +: WIDTH];
    b_sel    = op_b[int'(win_q)*WIDTH +: WIDTH];
    sum      = {1'b0, a_sel} + {1'b0, b_sel};
    ptr_next = (win_q == ID_W'(NUM_REQ-1)) ? '0 : win_q + ID_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    last_id_d  = last_id_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          gnt_d   = NUM_REQ'(1) << pick;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        {overflow_d, result_d} = sum;
        done_d    = gnt_q;
        last_id_d = win_q;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = S_RESP;
      end
      S_RESP: begin
        gnt_d    = '0;
        done_d   = '0;
        rr_ptr_d = ptr_next;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      last_id_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      last_id_q  <= last_id_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign last_id   = last_id_q;
  assign busy      = (state_q != S_IDLE);
  assign txn_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
`default_nettype none

module tb_sum_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          btn_reset;
  logic [N-1:0]  req;
  logic [N*W-1:0] op_a, op_b;

  logic [N-1:0]  gnt, done;
  logic [W-1:0]  result;
  logic          overflow;
  logic [1:0]    last_id;
  logic          busy;
  logic [15:0]   txn_count;

  logic [N-1:0]  w_gnt, w_done;
  logic [W-1:0]  w_result;
  logic          w_overflow;
  logic [1:0]    w_last_id;
  logic          w_busy;
  logic [3:0]    w_txn_count;

  int total = 0;
  int bad   = 0;
  int order[$];

  // transaction-level reference: age -1 idle, 0 granted, 1 completing
  int m_ptr, m_win, m_age, m_cnt, m_last;
  int m_res, m_ovf;

  always #5 clk = ~clk;

  sum_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .btn_reset(btn_reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .result(result), .overflow(overflow),
    .last_id(last_id), .busy(busy), .txn_count(txn_count)
  );

  // Narrow counter copy shows wrap-to-zero within a short run.
  sum_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(4)) u_wrap (
    .clk(clk), .btn_reset(btn_reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(w_gnt), .done(w_done), .result(w_result), .overflow(w_overflow),
    .last_id(w_last_id), .busy(w_busy), .txn_count(w_txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_win = 0; m_age = -1; m_cnt = 0; m_last = 0; m_res = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int w, s;
    if (m_age < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin
        m_win = w;
        m_age = 0;
      end
    end else if (m_age == 0) begin
      s = int'(op_a[m_win*W +: W]) + int'(op_b[m_win*W +: W]);
      m_res  = s % 256;
      m_ovf  = s / 256;
      m_last = m_win;
      m_cnt++;
      m_age  = 1;
    end else begin
      m_ptr = (m_win + 1) % N;
      m_age = -1;
    end
  endtask

  task automatic check_all();
    chk("gnt",       32'(gnt),        (m_age >= 0) ? (32'd1 << m_win) : 32'd0);
    chk("done",      32'(done),       (m_age == 1) ? (32'd1 << m_win) : 32'd0);
    chk("result",    32'(result),     32'(m_res));
    chk("overflow",  32'(overflow),   32'(m_ovf));
    chk("last_id",   32'(last_id),    32'(m_last));
    chk("busy",      32'(busy),       (m_age >= 0) ? 32'd1 : 32'd0);
    chk("txn_count", 32'(txn_count),  32'(m_cnt % 65536));
    chk("txn_wrap",  32'(w_txn_count), 32'(m_cnt % 16));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (done != '0) order.push_back(int'(last_id));
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[id*W +: W] = a;
    op_b[id*W +: W] = b;
  endtask

  task automatic async_reset();
    #2;
    btn_reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    btn_reset = 1'b1;
  endtask

  initial begin
    btn_reset = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    model_reset();
    #1 btn_reset = 1'b0;
    #2 check_all();
    @(negedge clk);
    btn_reset = 1'b1;

    // single requester 2
    set_ops(2, 8'h3C, 8'h05);
    req = 4'b0100;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    chk("t1_done", 32'(done), 32'h4);
    chk("t1_result", 32'(result), 32'h41);
    chk("t1_ovf", 32'(overflow), 32'h0);
    chk("t1_id", 32'(last_id), 32'h2);
    tick();
    tick();

    // carry-out and max-without-carry on requester 0
    set_ops(0, 8'hFF, 8'h01);
    req = 4'b0001;
    tick(); req = '0; tick();
    chk("t2a_result", 32'(result), 32'h00);
    chk("t2a_ovf", 32'(overflow), 32'h1);
    tick();
    set_ops(0, 8'h80, 8'h7F);
    req = 4'b0001;
    tick(); req = '0; tick();
    chk("t2b_result", 32'(result), 32'hFF);
    chk("t2b_ovf", 32'(overflow), 32'h0);
    tick();

    // fairness from a fresh reset with all requests held
    async_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(8'h11 * (i + 1)), W'(8'hF0 + i));
    order.delete();
    req = 4'b1111;
    for (int i = 0; i < 24; i++) tick();
    req = '0;
    chk("t3_count", 32'(txn_count), 32'd8);
    chk("t3_len", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8 && i < order.size(); i++) chk("t3_order", 32'(order[i]), 32'(i % N));

    // rr pointer past requester 1 gives 3 priority over 1
    req = 4'b0010;
    tick(); req = '0; tick(); tick();
    order.delete();
    req = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    req = '0;
    chk("t4_len", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("t4_first", 32'(order[0]), 32'd3);
      chk("t4_second", 32'(order[1]), 32'd1);
    end
    tick();

    // reset during ADD aborts the transaction
    req = 4'b0001;
    tick();
    async_reset();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(txn_count), 32'd0);
    req = 4'b1111;
    tick();
    chk("t5_restart", 32'(gnt), 32'h1);
    req = '0;
    tick(); tick(); tick();

    // random traffic, including runs past the narrow counter wrap
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      op_a = $urandom;
      op_b = $urandom;
      if ($urandom_range(0, 7) == 0) op_a = '1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
